// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: forwards non-memory ops to writeback and runs
// one cache transaction per memory op. Optional request timeout: MEM_TIMEOUT_EN.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_to_reg,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic        reg_write_en,
  input  logic        cache_en,
  input  logic        jal,
  input  logic        halted,
  input  logic [4:0]  write_register,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_val,
  input  logic [31:0] PC,
  output logic        stall,
  output logic        cache_req,
  output logic        cache_we,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wdata,
  input  logic        cache_ready,
  input  logic        cache_rvalid,
  input  logic [31:0] cache_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write_en,
  output logic        wb_halted,
  output logic [4:0]  wb_write_register,
  output logic [31:0] wb_data,
  output logic        mem_error,
  output logic [1:0]  dbg_state
);

  // Cache handshake: cache_req is held with stable addr/we/wdata until a cycle
  // with cache_ready; read data is taken on the first cache_rvalid from that
  // cycle on, and cache_rvalid in any other state is dropped.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] cache_addr_q, cache_addr_d;
  logic [31:0] cache_wdata_q, cache_wdata_d;
  logic        cache_we_q, cache_we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        op_m2r_q, op_m2r_d;
  logic        op_rwe_q, op_rwe_d;
  logic        op_halted_q, op_halted_d;
  logic [4:0]  op_wreg_q, op_wreg_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_rwe_q, wb_rwe_d;
  logic        wb_halted_q, wb_halted_d;
  logic [4:0]  wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mem_op;
  logic        timeout;
  logic        tmo_done;

  assign mem_op = (mem_read_en | mem_write_en) & cache_en & ~wb_halted_q;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       timed_out_q, timed_out_d;
  logic       mem_error_q, mem_error_d;

  assign timeout   = ((state_q == REQ) || (state_q == WAIT)) && (tmo_cnt_q == 8'd254);
  assign tmo_done  = timed_out_q;
  assign mem_error = mem_error_q;

  // Counter is zero whenever a transaction starts; it reaches 255 on the edge
  // that abandons the request.
  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    timed_out_d = timed_out_q;
    mem_error_d = mem_error_q;
    if (state_q == IDLE) begin
      tmo_cnt_d   = 8'd0;
      timed_out_d = 1'b0;
    end else if ((state_q == REQ) || (state_q == WAIT)) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
      if (timeout) begin
        timed_out_d = 1'b1;
        mem_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      tmo_cnt_q   <= 8'd0;
      timed_out_q <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      timed_out_q <= timed_out_d;
      mem_error_q <= mem_error_d;
    end
  end
`else
  assign timeout   = 1'b0;
  assign tmo_done  = 1'b0;
  assign mem_error = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cache_addr_d  = cache_addr_q;
    cache_wdata_d = cache_wdata_q;
    cache_we_d    = cache_we_q;
    rdata_d       = rdata_q;
    op_m2r_d      = op_m2r_q;
    op_rwe_d      = op_rwe_q;
    op_halted_d   = op_halted_q;
    op_wreg_d     = op_wreg_q;
    wb_valid_d    = 1'b0;
    wb_rwe_d      = wb_rwe_q;
    wb_halted_d   = wb_halted_q;
    wb_wreg_d     = wb_wreg_q;
    wb_data_d     = wb_data_q;
    stall         = 1'b0;
    cache_req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          stall         = 1'b1;
          cache_addr_d  = alu_result;
          cache_wdata_d = store_val;
          cache_we_d    = mem_write_en;
          op_m2r_d      = mem_to_reg;
          op_rwe_d      = reg_write_en;
          op_halted_d   = halted;
          op_wreg_d     = write_register;
          state_d       = REQ;
        end else if (!wb_halted_q) begin
          wb_valid_d  = 1'b1;
          wb_rwe_d    = reg_write_en;
          wb_wreg_d   = write_register;
          wb_data_d   = jal ? (PC + 32'd4) : alu_result;
          wb_halted_d = halted;
        end
      end
      REQ: begin
        stall     = 1'b1;
        cache_req = 1'b1;
        if (timeout) begin
          state_d = DONE;
        end else if (cache_ready) begin
          if (cache_we_q) begin
            state_d = DONE;
          end else if (cache_rvalid) begin
            rdata_d = cache_rdata;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (timeout) begin
          state_d = DONE;
        end else if (cache_rvalid) begin
          rdata_d = cache_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_valid_d  = 1'b1;
        wb_rwe_d    = op_rwe_q;
        wb_wreg_d   = op_wreg_q;
        wb_halted_d = op_halted_q;
        if (tmo_done)                   wb_data_d = 32'd0;
        else if (op_m2r_q && !cache_we_q) wb_data_d = rdata_q;
        else                              wb_data_d = cache_addr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q       <= IDLE;
      cache_addr_q  <= 32'd0;
      cache_wdata_q <= 32'd0;
      cache_we_q    <= 1'b0;
      rdata_q       <= 32'd0;
      op_m2r_q      <= 1'b0;
      op_rwe_q      <= 1'b0;
      op_halted_q   <= 1'b0;
      op_wreg_q     <= 5'd0;
      wb_valid_q    <= 1'b0;
      wb_rwe_q      <= 1'b0;
      wb_halted_q   <= 1'b0;
      wb_wreg_q     <= 5'd0;
      wb_data_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      cache_addr_q  <= cache_addr_d;
      cache_wdata_q <= cache_wdata_d;
      cache_we_q    <= cache_we_d;
      rdata_q       <= rdata_d;
      op_m2r_q      <= op_m2r_d;
      op_rwe_q      <= op_rwe_d;
      op_halted_q   <= op_halted_d;
      op_wreg_q     <= op_wreg_d;
      wb_valid_q    <= wb_valid_d;
      wb_rwe_q      <= wb_rwe_d;
      wb_halted_q   <= wb_halted_d;
      wb_wreg_q     <= wb_wreg_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign cache_addr        = cache_addr_q;
  assign cache_wdata       = cache_wdata_q;
  assign cache_we          = cache_we_q;
  assign wb_valid          = wb_valid_q;
  assign wb_reg_write_en   = wb_rwe_q;
  assign wb_halted         = wb_halted_q;
  assign wb_write_register = wb_wreg_q;
  assign wb_data           = wb_data_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, directed multi-cycle
// sequences and randomized instructions against a transaction-level model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        mem_to_reg, mem_read_en, mem_write_en, reg_write_en, cache_en, jal, halted;
  logic [4:0]  write_register;
  logic [31:0] alu_result, store_val, PC;
  logic        stall, cache_req, cache_we;
  logic [31:0] cache_addr, cache_wdata;
  logic        cache_ready, cache_rvalid;
  logic [31:0] cache_rdata;
  logic        wb_valid, wb_reg_write_en, wb_halted;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_data;
  logic        mem_error;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_b(rst_b),
    .mem_to_reg(mem_to_reg), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .reg_write_en(reg_write_en), .cache_en(cache_en), .jal(jal), .halted(halted),
    .write_register(write_register), .alu_result(alu_result), .store_val(store_val), .PC(PC),
    .stall(stall), .cache_req(cache_req), .cache_we(cache_we),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_ready(cache_ready), .cache_rvalid(cache_rvalid), .cache_rdata(cache_rdata),
    .wb_valid(wb_valid), .wb_reg_write_en(wb_reg_write_en), .wb_halted(wb_halted),
    .wb_write_register(wb_write_register), .wb_data(wb_data),
    .mem_error(mem_error), .dbg_state(dbg_state)
  );

  typedef struct {
    logic m2r, rd, wr, rwe, cen, jal, halted;
    logic [4:0]  wreg;
    logic [31:0] alu, sv, pc;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic        exp_stall;
    logic [31:0] exp_data;
  } vec_t;

  // Scoreboard entry: {halted, reg_write_en, write_register, data}
  logic [38:0] exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  bit          model_halted = 1'b0;
  vec_t        tv[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic m2r, rd, wr, rwe, cen, jl, hlt,
                                input logic [4:0] wreg, input logic [31:0] alu, sv, pc);
    instr_t i;
    i.m2r = m2r; i.rd = rd; i.wr = wr; i.rwe = rwe; i.cen = cen; i.jal = jl; i.halted = hlt;
    i.wreg = wreg; i.alu = alu; i.sv = sv; i.pc = pc;
    return i;
  endfunction

  task automatic drive(input instr_t i);
    mem_to_reg = i.m2r; mem_read_en = i.rd; mem_write_en = i.wr; reg_write_en = i.rwe;
    cache_en = i.cen; jal = i.jal; halted = i.halted; write_register = i.wreg;
    alu_result = i.alu; store_val = i.sv; PC = i.pc;
  endtask

  task automatic reset_dut();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0));
    cache_ready = 1'b0; cache_rvalid = 1'b0; cache_rdata = 32'd0;
    rst_b = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_b = 1'b1;
    model_halted = 1'b0;
    exp_q.delete();
  endtask

  // Reference: what an instruction should write back, from its fields alone.
  function automatic logic [31:0] ref_data(input instr_t i, input bit is_mem, input logic [31:0] rdata);
    if (is_mem) return (i.m2r && i.rd && !i.wr) ? rdata : i.alu;
    return i.jal ? i.pc + 32'd4 : i.alu;
  endfunction

  task automatic retire_check();
    logic [38:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wb_valid", 64'(wb_valid), 64'(1));
      chk("wb_entry", 64'({wb_halted, wb_reg_write_en, wb_write_register, wb_data}), 64'(e));
    end else begin
      chk("wb_quiet", 64'(wb_valid), 64'(0));
    end
    chk("wb_halted", 64'(wb_halted), 64'(model_halted));
  endtask

  // Called at posedge+1; returns at posedge+1 right after the retiring edge.
  task automatic issue(input instr_t ins, input int rdy_dly, input int rv_dly, input logic [31:0] rdata);
    bit     is_mem, is_rd;
    instr_t junk;
    is_mem = (ins.rd | ins.wr) & ins.cen & !model_halted;
    is_rd  = ins.rd & !ins.wr;
    drive(ins);
    if (!model_halted) begin
      exp_q.push_back({ins.halted, ins.rwe, ins.wreg, ref_data(ins, is_mem, rdata)});
      if (ins.halted) model_halted = 1'b1;
    end
    #1;
    chk("stall_issue", 64'(stall), 64'(is_mem));
    @(posedge clk); #1;
    if (is_mem) begin
      for (int i = 0; i < rdy_dly; i++) begin
        chk("req_wait_ready", 64'({cache_req, stall, wb_valid}), 64'(3'b110));
        @(posedge clk); #1;
      end
      chk("cache_req", 64'(cache_req), 64'(1));
      chk("cache_addr", 64'(cache_addr), 64'(ins.alu));
      chk("cache_we", 64'(cache_we), 64'(ins.wr));
      chk("cache_wdata", 64'(cache_wdata), 64'(ins.sv));
      cache_ready = 1'b1;
      if (is_rd && rv_dly == 0) begin cache_rvalid = 1'b1; cache_rdata = rdata; end
      #1;
      chk("stall_ready", 64'(stall), 64'(1));
      @(posedge clk); #1;
      cache_ready = 1'b0; cache_rvalid = 1'b0;
      if (is_rd && rv_dly > 0) begin
        for (int j = 1; j < rv_dly; j++) begin
          chk("wait_rvalid", 64'({cache_req, stall, wb_valid}), 64'(3'b010));
          @(posedge clk); #1;
        end
        chk("stall_rvalid", 64'(stall), 64'(1));
        cache_rvalid = 1'b1; cache_rdata = rdata;
        @(posedge clk); #1;
        cache_rvalid = 1'b0;
      end
      // DONE: inputs and a stray cache_rvalid must be ignored.
      junk = mk(1, 1, 0, 1, 1, 1, 1, 5'($urandom), $urandom, $urandom, $urandom);
      drive(junk);
      cache_rvalid = 1'b1; cache_rdata = ~rdata;
      #1;
      chk("done_quiet", 64'({stall, cache_req, wb_valid}), 64'(3'b000));
      @(posedge clk); #1;
      cache_rvalid = 1'b0;
    end else begin
      chk("nonmem_no_req", 64'(cache_req), 64'(0));
    end
    retire_check();
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    int     kind;
    kind = $urandom_range(0, 3);
    i = mk($urandom_range(0, 1), 0, 0, $urandom_range(0, 1), 0, 0, 0,
           5'($urandom), $urandom, $urandom, $urandom);
    case (kind)
      0: i.jal = $urandom_range(0, 1);
      1: begin i.rd = 1; i.cen = 1; end
      2: begin i.wr = 1; i.cen = 1; end
      default: begin i.rd = $urandom_range(0, 1); i.wr = !i.rd; end
    endcase
    return i;
  endfunction

  initial begin
    int n;

    tv[0] = '{ins: mk(0, 0, 0, 1, 0, 0, 0, 5'd5,  32'h0000_1234, 32'd0, 32'd0),        exp_stall: 1'b0, exp_data: 32'h0000_1234};
    tv[1] = '{ins: mk(0, 0, 0, 1, 0, 1, 0, 5'd31, 32'hAAAA_0000, 32'd0, 32'hFFFF_FFFC), exp_stall: 1'b0, exp_data: 32'h0000_0000};
    tv[2] = '{ins: mk(0, 0, 0, 1, 1, 1, 0, 5'd1,  32'h0000_AAAA, 32'd0, 32'h0000_1000), exp_stall: 1'b0, exp_data: 32'h0000_1004};
    tv[3] = '{ins: mk(1, 1, 0, 1, 0, 0, 0, 5'd9,  32'h0000_0040, 32'd7, 32'h0000_0010), exp_stall: 1'b0, exp_data: 32'h0000_0040};
    tv[4] = '{ins: mk(0, 0, 1, 0, 0, 0, 0, 5'd17, 32'hFFFF_FFFF, 32'd9, 32'h0000_0020), exp_stall: 1'b0, exp_data: 32'hFFFF_FFFF};
    tv[5] = '{ins: mk(0, 0, 0, 0, 1, 0, 0, 5'd0,  32'h0000_0000, 32'd0, 32'h8000_0000), exp_stall: 1'b0, exp_data: 32'h0000_0000};

    // Reset state
    reset_dut();
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("rst_state", 64'(dbg_state), 64'(0));
    chk("rst_cache", 64'({cache_req, cache_we, cache_addr, cache_wdata}), 64'(0));
    chk("rst_wb", 64'({wb_valid, wb_reg_write_en, wb_halted, wb_write_register, wb_data}), 64'(0));
    chk("rst_mem_error", 64'(mem_error), 64'(0));
    rst_b = 1'b1;

    // Non-memory vector table
    for (int k = 0; k < 6; k++) begin
      drive(tv[k].ins);
      #1;
      chk("tv_stall", 64'(stall), 64'(tv[k].exp_stall));
      @(posedge clk); #1;
      chk("tv_wb_valid", 64'(wb_valid), 64'(1));
      chk("tv_wb_data", 64'(wb_data), 64'(tv[k].exp_data));
      chk("tv_wb_reg", 64'(wb_write_register), 64'(tv[k].ins.wreg));
      chk("tv_wb_rwe", 64'(wb_reg_write_en), 64'(tv[k].ins.rwe));
    end

    // Load at 0x40: ready 2 cycles into REQ, rvalid 3 cycles after ready
    issue(mk(1, 1, 0, 1, 1, 0, 0, 5'd3, 32'h40, 32'd0, 32'h100), 2, 3, 32'hDEAD_BEEF);
    // Store at 0x80
    issue(mk(0, 0, 1, 0, 1, 0, 0, 5'd4, 32'h80, 32'h55, 32'h104), 1, 0, 32'd0);
    // Read with ready and rvalid together: straight to DONE
    issue(mk(1, 1, 0, 1, 1, 0, 0, 5'd6, 32'hC0, 32'd0, 32'h108), 0, 0, 32'hCAFE_F00D);
    // Read without mem_to_reg writes back the address
    issue(mk(0, 1, 0, 1, 1, 0, 0, 5'd8, 32'hC4, 32'd0, 32'h10C), 1, 2, 32'h1111_2222);

    // Randomized instruction stream
    for (int r = 0; r < 40; r++)
      issue(rand_instr(), $urandom_range(0, 4), $urandom_range(0, 4), $urandom);

    // Reset in WAIT; a late response must not retire anything
    drive(mk(1, 1, 0, 1, 1, 0, 0, 5'd12, 32'h100, 32'd0, 32'h200));
    @(posedge clk); #1;
    cache_ready = 1'b1;
    @(posedge clk); #1;
    cache_ready = 1'b0;
    chk("in_wait", 64'(dbg_state), 64'(2));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0));
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("rst_wait_state", 64'(dbg_state), 64'(0));
    chk("rst_wait_out", 64'({cache_req, wb_valid, cache_addr}), 64'(0));
    cache_rvalid = 1'b1; cache_rdata = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    chk("late_rvalid_rst", 64'({wb_valid, dbg_state}), 64'(0));
    rst_b = 1'b1;
    issue(mk(0, 0, 0, 1, 0, 0, 0, 5'd13, 32'h3333, 32'd0, 32'd0), 0, 0, 32'd0);
    cache_rvalid = 1'b0;

    // Unanswered request
    reset_dut();
    drive(mk(1, 1, 0, 1, 1, 0, 0, 5'd7, 32'h200, 32'd0, 32'h300));
    #1;
    chk("tmo_stall", 64'(stall), 64'(1));
    @(posedge clk); #1;
    n = 0;
    while (stall && n < 400) begin @(posedge clk); #1; n++; end
`ifdef MEM_TIMEOUT_EN
    chk("tmo_cycles", 64'(n), 64'(255));
    chk("tmo_mem_error", 64'(mem_error), 64'(1));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0));
    @(posedge clk); #1;
    chk("tmo_wb", 64'({wb_valid, wb_write_register, wb_data}), 64'({1'b1, 5'd7, 32'd0}));
`else
    chk("no_tmo_stall", 64'(n), 64'(400));
    chk("no_tmo_mem_error", 64'(mem_error), 64'(0));
`endif
    reset_dut();
    chk("mem_error_cleared", 64'(mem_error), 64'(0));

    // Halt: sticky, no more requests or writebacks
    issue(mk(0, 0, 0, 1, 0, 0, 1, 5'd2, 32'h77, 32'd0, 32'd0), 0, 0, 32'd0);
    issue(mk(1, 1, 0, 1, 1, 0, 0, 5'd3, 32'h44, 32'd0, 32'd0), 0, 0, 32'd0);
    issue(mk(0, 0, 0, 1, 0, 1, 0, 5'd4, 32'h88, 32'd0, 32'h10), 0, 0, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("halt_hold", 64'({wb_halted, wb_valid, cache_req}), 64'(3'b100));

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 clk  input  1  Pipeline clock; all state updates on the rising edge.
REQ-002 rst_b  input  1  Reset; synchronous, active-low.
REQ-003 mem_to_reg, mem_read_en, mem_write_en, reg_write_en, cache_en, jal, halted  input  1 each  Control from the EXE/MEM pipeline register.
REQ-004 write_register  input  5  Destination register index.
REQ-005 alu_result  input  32  ALU result, also the memory byte address.
REQ-006 store_val  input  32  Store data.
REQ-007 PC  input  32  Instruction PC.
REQ-008 stall  output  1  Holds the upstream EXE/MEM register; combinational.
REQ-009 cache_req, cache_we  output  1  Cache request strobe and write select.
REQ-010 cache_addr, cache_wdata  output  32  Request address and write data; registered.
REQ-011 cache_ready, cache_rvalid  input  1  Cache accepted request; read data valid.
REQ-012 cache_rdata  input  32  Read data.
REQ-013 wb_valid, wb_reg_write_en, wb_halted  output  1  Writeback strobe, register-write enable, sticky halt.
REQ-014 wb_write_register  output  5  Writeback destination.
REQ-015 wb_data  output  32  Writeback value.
REQ-016 mem_error  output  1  Sticky timeout flag (see Configuration).

Function
REQ-017 A memory op SHALL be defined as (mem_read_en | mem_write_en) & cache_en & ~wb_halted; cache_en=0 SHALL make the instruction a non-memory op.
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-019 IDLE, non-memory op: next edge SHALL load wb_* with wb_valid=1, wb_data = jal ? PC+4 (mod 2^32) : alu_result; stall=0.
REQ-020 IDLE, memory op: stall=1 combinationally; next edge SHALL capture address, store_val, write enable, and the wb fields into internal registers and enter REQ.
REQ-021 REQ: cache_req=1 with stable cache_addr/cache_we/cache_wdata; stall=1; on cache_ready a write SHALL go to DONE and a read to WAIT.
REQ-022 REQ, read, cache_ready and cache_rvalid in the same cycle: SHALL capture cache_rdata and go directly to DONE.
REQ-023 WAIT: stall=1; on cache_rvalid SHALL capture cache_rdata and go to DONE; cache_rvalid outside REQ/WAIT SHALL be ignored.
REQ-024 DONE: stall=0 and inputs ignored; next edge SHALL load wb_* (wb_valid=1, wb_data = captured rdata for reads with mem_to_reg, else captured alu_result) and return to IDLE.
REQ-025 wb_valid SHALL be a one-cycle pulse per retired instruction; wb_valid=0 in all other cycles.
REQ-026 When halted=1 retires, wb_halted SHALL set and remain 1 until reset; no further cache requests SHALL issue and wb_valid SHALL stay 0 thereafter.

Reset
REQ-027 While rst_b=0 at a rising edge, state SHALL become IDLE and every registered output (cache_addr, cache_wdata, cache_we, wb_*, mem_error) SHALL become 0, including mid-transaction. cache_req SHALL be 0 from that edge.
REQ-028 Outstanding cache responses arriving after reset SHALL be ignored.

Configuration
REQ-029 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL count cycles in REQ/WAIT, clearing on entry to REQ; on reaching 255 the FSM SHALL go to DONE with wb_data=0 and set mem_error until reset.
REQ-030 Without MEM_TIMEOUT_EN, no counter SHALL exist, mem_error SHALL be tied 0, and REQ/WAIT SHALL wait indefinitely.

Verification
REQ-031 Non-memory op: alu_result=0x1234, reg_write_en=1, write_register=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_write_register=5, stall=0.
REQ-032 jal=1, PC=0xFFFFFFFC -> wb_data=0x00000000 (wrap).
REQ-033 Load at 0x40, cache_ready 2 cycles after cache_req, cache_rvalid 3 cycles later with 0xDEADBEEF -> stall high throughout, wb_data=0xDEADBEEF one cycle after DONE.
REQ-034 Store at 0x80 with store_val=0x55 -> cache_we=1, cache_wdata=0x55; cache_ready and cache_rvalid in the same cycle on a read -> REQ goes directly to DONE.
REQ-035 rst_b=0 during WAIT -> next edge state IDLE, cache_req=0, wb_valid=0; a late cache_rvalid produces no writeback.
REQ-036 MEM_TIMEOUT_EN defined, cache_ready never asserted -> after 255 cycles mem_error=1, wb_valid pulses with wb_data=0; without the macro, stall remains 1.
